// File: rtl/demux_pkg.sv
// Shared types and sizing for the demux scan controller.
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/demux_scan_ctrl_if.sv
// Word handshake in, demux drive and status out.
interface demux_scan_ctrl_if;
    import demux_pkg::*;

    logic [NUM_CH-1:0] data_in;
    logic [NUM_CH-1:0] mask_in;
    logic              valid_in;
    logic              ready_out;
    logic              dmx_in;
    logic [SEL_W-1:0]  dmx_sel;
    logic              dmx_en;
    logic              busy;
    logic              done;

    modport master (
        output data_in, mask_in, valid_in,
        input  ready_out, dmx_in, dmx_sel, dmx_en, busy, done
    );

    modport slave (
        input  data_in, mask_in, valid_in,
        output ready_out, dmx_in, dmx_sel, dmx_en, busy, done
    );
endinterface

// File: rtl/demux_next_ch.sv
// Lowest set mask bit strictly above idx_i; start_i treats idx as -1.
module demux_next_ch
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  idx_i,
    input  logic              start_i,
    output logic [SEL_W-1:0]  ch_o,
    output logic              none_o
);

    // Descending scan so the lowest qualifying bit is the last one written.
    always_comb begin
        ch_o   = '0;
        none_o = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (start_i || (SEL_W'(i) > idx_i))) begin
                ch_o   = SEL_W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Serialises a captured word onto a 1x8 demux, one enabled channel at a time.
//   state | meaning
//   IDLE  | ready for a word, all drive outputs low
//   SHIFT | driving dmx_in/dmx_sel for the current channel
//   DONE  | one-cycle completion pulse, then back to IDLE
module demux_scan_ctrl
    import demux_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    demux_scan_ctrl_if.slave   bus
);

    localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] data_q,  data_d;
    logic [NUM_CH-1:0] mask_q,  mask_d;
    logic [3:0]        hold_q,  hold_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic              din_q,   din_d;

    logic              in_idle;
    logic [NUM_CH-1:0] scan_mask;
    logic [SEL_W-1:0]  nxt_ch;
    logic              nxt_none;

    assign in_idle = (state_q == IDLE);

    // In IDLE the search runs over the incoming mask so the first channel
    // can be registered on the accept edge itself.
    assign scan_mask = in_idle ? bus.mask_in : mask_q;

    demux_next_ch u_next_ch (
        .mask_i  (scan_mask),
        .idx_i   (sel_q),
        .start_i (in_idle),
        .ch_o    (nxt_ch),
        .none_o  (nxt_none)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    data_d = bus.data_in;
                    mask_d = bus.mask_in;
                    if (nxt_none) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                        sel_d   = nxt_ch;
                        din_d   = bus.data_in[nxt_ch];
                        hold_d  = HOLD_LD;
                    end
                end
            end
            SHIFT: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else if (nxt_none) begin
                    state_d = DONE;
                    sel_d   = '0;
                    din_d   = 1'b0;
                end else begin
                    sel_d  = nxt_ch;
                    din_d  = data_q[nxt_ch];
                    hold_d = HOLD_LD;
                end
            end
            DONE: begin
                state_d = IDLE;
                sel_d   = '0;
                din_d   = 1'b0;
                hold_d  = 4'd0;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                din_d   = 1'b0;
                hold_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            hold_q  <= 4'd0;
            sel_q   <= '0;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            din_q   <= din_d;
        end
    end

    assign bus.ready_out = in_idle;
    assign bus.dmx_en    = (state_q == SHIFT);
    assign bus.dmx_sel   = sel_q;
    assign bus.dmx_in    = din_q;
    assign bus.busy      = !in_idle;
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl at HOLD_CYCLES=1 and HOLD_CYCLES=3.
module tb_demux_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    demux_scan_ctrl_if bus1 ();
    demux_scan_ctrl_if bus3 ();

    demux_scan_ctrl #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    demux_scan_ctrl #(.HOLD_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a word on bus1 at a negedge; returns at the negedge of cycle 1.
    task automatic send1(input logic [7:0] d, input logic [7:0] m);
        bus1.data_in  = d;
        bus1.mask_in  = m;
        bus1.valid_in = 1'b1;
        chk("send_ready", {31'd0, bus1.ready_out}, 32'd1);
        @(negedge clk);
        bus1.valid_in = 1'b0;
    endtask

    task automatic chk_idle1(input string tag);
        chk({tag, "_ready"}, {31'd0, bus1.ready_out}, 32'd1);
        chk({tag, "_en"},    {31'd0, bus1.dmx_en},    32'd0);
        chk({tag, "_sel"},   {29'd0, bus1.dmx_sel},   32'd0);
        chk({tag, "_din"},   {31'd0, bus1.dmx_in},    32'd0);
        chk({tag, "_busy"},  {31'd0, bus1.busy},      32'd0);
        chk({tag, "_done"},  {31'd0, bus1.done},      32'd0);
    endtask

    initial begin
        logic [7:0] exp_a5;
        bus1.data_in = 8'h00; bus1.mask_in = 8'h00; bus1.valid_in = 1'b0;
        bus3.data_in = 8'h00; bus3.mask_in = 8'h00; bus3.valid_in = 1'b0;
        exp_a5 = 8'b1010_0101;

        repeat (2) @(negedge clk);
        chk_idle1("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_idle1("post_rst");
        chk("rst3_ready", {31'd0, bus3.ready_out}, 32'd1);
        chk("rst3_en",    {31'd0, bus3.dmx_en},    32'd0);

        // Full mask, alternating data bits.
        send1(8'hA5, 8'hFF);
        for (int c = 1; c <= 8; c++) begin
            chk("a5_en",   {31'd0, bus1.dmx_en},  32'd1);
            chk("a5_sel",  {29'd0, bus1.dmx_sel}, 32'(c - 1));
            chk("a5_din",  {31'd0, bus1.dmx_in},  {31'd0, exp_a5[c-1]});
            chk("a5_busy", {31'd0, bus1.busy},    32'd1);
            chk("a5_rdy",  {31'd0, bus1.ready_out}, 32'd0);
            @(negedge clk);
        end
        chk("a5_done",     {31'd0, bus1.done},    32'd1);
        chk("a5_done_en",  {31'd0, bus1.dmx_en},  32'd0);
        chk("a5_done_sel", {29'd0, bus1.dmx_sel}, 32'd0);
        chk("a5_done_rdy", {31'd0, bus1.ready_out}, 32'd0);
        @(negedge clk);
        chk_idle1("a5_end");

        // Sparse mask: skip from channel 0 straight to 7.
        send1(8'hFF, 8'h81);
        chk("81_sel0", {29'd0, bus1.dmx_sel}, 32'd0);
        chk("81_din0", {31'd0, bus1.dmx_in},  32'd1);
        @(negedge clk);
        chk("81_sel7", {29'd0, bus1.dmx_sel}, 32'd7);
        chk("81_en7",  {31'd0, bus1.dmx_en},  32'd1);
        @(negedge clk);
        chk("81_done", {31'd0, bus1.done},    32'd1);
        @(negedge clk);

        // Empty mask: straight to DONE, no drive.
        send1(8'hFF, 8'h00);
        chk("m0_en",   {31'd0, bus1.dmx_en}, 32'd0);
        chk("m0_done", {31'd0, bus1.done},   32'd1);
        chk("m0_busy", {31'd0, bus1.busy},   32'd1);
        @(negedge clk);
        chk("m0_rdy",  {31'd0, bus1.ready_out}, 32'd1);
        chk("m0_en2",  {31'd0, bus1.dmx_en}, 32'd0);

        // valid held with changing inputs during the scan.
        send1(8'h3C, 8'h0A);
        bus1.valid_in = 1'b1; bus1.data_in = 8'hFF; bus1.mask_in = 8'hF0;
        chk("bb_sel1", {29'd0, bus1.dmx_sel}, 32'd1);
        chk("bb_din1", {31'd0, bus1.dmx_in},  32'd0);
        @(negedge clk);
        bus1.data_in = 8'hC3; bus1.mask_in = 8'h01;
        chk("bb_sel3", {29'd0, bus1.dmx_sel}, 32'd3);
        chk("bb_din3", {31'd0, bus1.dmx_in},  32'd1);
        @(negedge clk);
        chk("bb_done", {31'd0, bus1.done},    32'd1);
        @(negedge clk);
        chk("bb_idle_rdy", {31'd0, bus1.ready_out}, 32'd1);
        @(negedge clk);
        bus1.valid_in = 1'b0;
        chk("bb2_en",  {31'd0, bus1.dmx_en},  32'd1);
        chk("bb2_sel", {29'd0, bus1.dmx_sel}, 32'd0);
        chk("bb2_din", {31'd0, bus1.dmx_in},  32'd1);
        @(negedge clk);
        chk("bb2_done", {31'd0, bus1.done},   32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of a scan.
        send1(8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        chk("ar_sel4", {29'd0, bus1.dmx_sel}, 32'd4);
        #2 rst = 1'b1;
        #1 chk_idle1("ar_async");
        @(negedge clk);
        chk("ar_nodone", {31'd0, bus1.done}, 32'd0);
        chk("ar_en",     {31'd0, bus1.dmx_en}, 32'd0);
        rst = 1'b0;
        send1(8'h10, 8'h10);
        chk("ar_new_sel", {29'd0, bus1.dmx_sel}, 32'd4);
        chk("ar_new_din", {31'd0, bus1.dmx_in},  32'd1);
        chk("ar_new_en",  {31'd0, bus1.dmx_en},  32'd1);
        @(negedge clk);
        chk("ar_new_done", {31'd0, bus1.done}, 32'd1);
        @(negedge clk);

        // Hold of three cycles per channel.
        bus3.data_in = 8'h04; bus3.mask_in = 8'h06; bus3.valid_in = 1'b1;
        chk("h3_ready", {31'd0, bus3.ready_out}, 32'd1);
        @(negedge clk);
        bus3.valid_in = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("h3_en",  {31'd0, bus3.dmx_en},  32'd1);
            chk("h3_sel", {29'd0, bus3.dmx_sel}, (c <= 3) ? 32'd1 : 32'd2);
            chk("h3_din", {31'd0, bus3.dmx_in},  (c <= 3) ? 32'd0 : 32'd1);
            chk("h3_done_low", {31'd0, bus3.done}, 32'd0);
            @(negedge clk);
        end
        chk("h3_done", {31'd0, bus3.done},   32'd1);
        chk("h3_en7",  {31'd0, bus3.dmx_en}, 32'd0);
        @(negedge clk);
        chk("h3_rdy",  {31'd0, bus3.ready_out}, 32'd1);
        chk("h3_busy", {31'd0, bus3.busy},   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
